// File: rtl/pipe_ctrl_seq_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl_seq.
// Statistics signals exist only when PIPE_CTRL_STATS_EN is defined.
interface pipe_ctrl_seq_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        timeout_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        stall_timeout;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] eret_count;
`endif

  // Pipeline side: raises requests, consumes stall/flush controls.
  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i, timeout_clr,
`ifdef PIPE_CTRL_STATS_EN
    input  stall_cycles, flush_count, eret_count,
`endif
    input  stall, flush, new_pc, busy, stall_timeout
  );

  // Controller side.
  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i, timeout_clr,
`ifdef PIPE_CTRL_STATS_EN
    output stall_cycles, flush_count, eret_count,
`endif
    output stall, flush, new_pc, busy, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: stall merge, exception flush sequencing, stall watchdog.
// Optional statistics counters are enabled with the PIPE_CTRL_STATS_EN macro.
module pipe_ctrl_seq #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  pipe_ctrl_seq_if.slave bus
);

  localparam logic [31:0] ERET_CODE    = 32'h0000_000e;
  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT     = 16'(STALL_TIMEOUT - 1);
  localparam logic        MULTI_FLUSH  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // The deepest requesting stage freezes itself and everything upstream of it.
  function automatic logic [5:0] stall_mask(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
    logic [5:0] mask;
    if (req_mem) begin
      mask = 6'b011111;
    end else if (req_ex) begin
      mask = 6'b001111;
    end else if (req_id) begin
      mask = 6'b000111;
    end else if (req_if) begin
      mask = 6'b000011;
    end else begin
      mask = 6'b000000;
    end
    return mask;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  logic [5:0]  stall_s;
  logic        flush_s;
  logic        busy_s;
  logic [31:0] new_pc_s;
  logic        exc_s;
  logic        eret_s;

  assign exc_s  = (bus.excepttype_i != 32'h0000_0000);
  assign eret_s = (bus.excepttype_i == ERET_CODE);

  // Sequencer state and latched redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 4'd0;
      new_pc_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      new_pc_q    <= new_pc_d;
    end
  end

  // Next-state and stall/flush outputs.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    stall_s     = 6'b000000;
    flush_s     = 1'b0;
    busy_s      = 1'b0;
    new_pc_s    = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_s) begin
          // An exception overrides every stall request in the same cycle.
          flush_s  = 1'b1;
          new_pc_s = eret_s ? bus.cp0_epc_i : EXC_VECTOR;
          new_pc_d = new_pc_s;
          if (MULTI_FLUSH) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d     = ST_IDLE;
            flush_cnt_d = 4'd0;
          end
        end else begin
          stall_s = stall_mask(bus.stallreq_from_if, bus.stallreq_from_id,
                               bus.stallreq_from_ex, bus.stallreq_from_mem);
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        busy_s  = 1'b1;
        if (flush_cnt_q <= 4'd1) begin
          state_d     = ST_IDLE;
          flush_cnt_d = 4'd0;
        end else begin
          state_d     = ST_FLUSH;
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Counter saturates at the limit so the flag keeps being reasserted until cleared.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (bus.timeout_clr) begin
      wd_cnt_d  = 16'd0;
      timeout_d = 1'b0;
    end else if (stall_s[0]) begin
      if (wd_cnt_q == WD_LIMIT) begin
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 16'd1;
      end
    end else begin
      wd_cnt_d = 16'd0;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] eret_count_q, eret_count_d;

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
      eret_count_q   <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      eret_count_q   <= eret_count_d;
    end
  end

  // Exception entries only happen from IDLE; FLUSH ignores excepttype_i.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    eret_count_d   = eret_count_q;
    if (stall_s != 6'b000000) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if ((state_q == ST_IDLE) && exc_s) begin
      flush_count_d = flush_count_q + 32'd1;
      if (eret_s) begin
        eret_count_d = eret_count_q + 32'd1;
      end else begin
        eret_count_d = eret_count_q;
      end
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
  assign bus.eret_count   = eret_count_q;
`endif

  // Outputs are forced low while reset is held, even mid-cycle.
  assign bus.stall         = rst ? 6'b000000 : stall_s;
  assign bus.flush         = rst ? 1'b0 : flush_s;
  assign bus.busy          = rst ? 1'b0 : busy_s;
  assign bus.new_pc        = rst ? 32'h0000_0000 : new_pc_s;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Randomized self-checking bench for pipe_ctrl_seq against a cycle-level behavioural model.
// Statistics checks are compiled in when PIPE_CTRL_STATS_EN is defined.
module tb_pipe_ctrl_seq;
  localparam int          FC      = 3;
  localparam int          ST      = 8;
  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam logic [31:0] ERET    = 32'h0000_000e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_seq_if bus ();

  pipe_ctrl_seq #(
    .EXC_VECTOR    (EXC_VEC),
    .FLUSH_CYCLES  (FC),
    .STALL_TIMEOUT (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: remaining flush cycles, latched target, stall run length.
  int          m_flush_left;
  logic [31:0] m_pc;
  int          m_run;
  logic        m_flag;
  logic [31:0] m_stall_cycles;
  logic [31:0] m_flush_count;
  logic [31:0] m_eret_count;
  int          flush_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left   = 0;
    m_pc           = 32'h0;
    m_run          = 0;
    m_flag         = 1'b0;
    m_stall_cycles = 32'h0;
    m_flush_count  = 32'h0;
    m_eret_count   = 32'h0;
  endtask

  task automatic set_inputs(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                            input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    bus.stallreq_from_if  = r_if;
    bus.stallreq_from_id  = r_id;
    bus.stallreq_from_ex  = r_ex;
    bus.stallreq_from_mem = r_mem;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
    bus.timeout_clr       = clr;
  endtask

  task automatic run_cycle(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                           input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        e_busy;
    logic [31:0] e_pc;
    @(negedge clk);
    set_inputs(r_if, r_id, r_ex, r_mem, exc, epc, clr);
    #2;
    e_pc = m_pc;
    if (m_flush_left > 0) begin
      e_flush = 1'b1; e_busy = 1'b1; e_stall = 6'h00;
    end else if (exc != 32'h0) begin
      e_flush = 1'b1; e_busy = 1'b0; e_stall = 6'h00;
      e_pc = (exc == ERET) ? epc : EXC_VEC;
    end else begin
      e_flush = 1'b0; e_busy = 1'b0;
      // Stages 0..k stop, k = deepest requesting stage's index
      if (r_mem)     e_stall = 6'(2 ** 5 - 1);
      else if (r_ex) e_stall = 6'(2 ** 4 - 1);
      else if (r_id) e_stall = 6'(2 ** 3 - 1);
      else if (r_if) e_stall = 6'(2 ** 2 - 1);
      else           e_stall = 6'h00;
    end
    check_eq("stall", 32'(bus.stall), 32'(e_stall));
    check_eq("flush", 32'(bus.flush), 32'(e_flush));
    check_eq("busy", 32'(bus.busy), 32'(e_busy));
    check_eq("stall_timeout", 32'(bus.stall_timeout), 32'(m_flag));
    if (e_flush) check_eq("new_pc", bus.new_pc, e_pc);
`ifdef PIPE_CTRL_STATS_EN
    check_eq("stall_cycles", bus.stall_cycles, m_stall_cycles);
    check_eq("flush_count", bus.flush_count, m_flush_count);
    check_eq("eret_count", bus.eret_count, m_eret_count);
`endif
    flush_seen += int'(bus.flush);
    @(posedge clk);
    if (e_stall != 6'h00) m_stall_cycles++;
    if (m_flush_left == 0 && exc != 32'h0) begin
      m_flush_count++;
      if (exc == ERET) m_eret_count++;
    end
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (exc != 32'h0) begin
      m_pc = e_pc;
      m_flush_left = FC - 1;
    end
    if (clr) begin
      m_run = 0; m_flag = 1'b0;
    end else if (e_stall[0]) begin
      m_run++;
      if (m_run >= ST) m_flag = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] exc_r;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    flush_seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check_eq("rst_stall", 32'(bus.stall), 32'h0);
    check_eq("rst_flush", 32'(bus.flush), 32'h0);
    check_eq("rst_new_pc", bus.new_pc, 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    idle(2);

    // Priority merge.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("id_ex_stall", 32'(bus.stall), 32'h0000_000f);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    check_eq("mem_stall", 32'(bus.stall), 32'h0000_001f);
    idle(1);

    // Exception with concurrent mem stall: flush exactly FC cycles.
    flush_seen = 0;
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("flush_len", 32'(flush_seen), 32'd3);

    // eret: target latched, EPC changes ignored during FLUSH.
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, ERET, 32'h0040_0104, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    check_eq("eret_pc_hold", bus.new_pc, 32'h0040_0104);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'hdead_beef, 1'b0);
    // Back-to-back exceptions in IDLE.
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000c, 32'h0, 1'b0);
    idle(2);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, ERET, 32'h0000_1000, 1'b0);
    idle(3);

    // Watchdog: ST consecutive stall cycles, sticky, cleared by pulse.
    for (int i = 0; i < ST; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);
    check_eq("timeout_sticky", 32'(bus.stall_timeout), 32'h1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(1);
    check_eq("timeout_cleared", 32'(bus.stall_timeout), 32'h0);

    // Async reset mid-cycle during FLUSH, with a request held.
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_flush", 32'(bus.flush), 32'h0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("mid_rst_stall", 32'(bus.stall), 32'h0);
    check_eq("mid_rst_new_pc", bus.new_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(1);

`ifdef PIPE_CTRL_STATS_EN
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
    idle(2);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, ERET, 32'h0000_0400, 1'b0);
    idle(3);
    check_eq("stats_stall", bus.stall_cycles, 32'd5);
    check_eq("stats_flush", bus.flush_count, 32'd2);
    check_eq("stats_eret", bus.eret_count, 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      exc_r = 32'h0;
      if ($urandom_range(0, 9) == 0) begin
        exc_r = ($urandom_range(0, 2) == 0) ? ERET : ($urandom() | 32'h1);
      end
      run_cycle(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 25),
                1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 10),
                exc_r, $urandom(), 1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Pipeline control sequencer for the 6-stage MIPS core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the shared stall[5:0] vector.
- Sequences exception flushes: drives flush to every pipeline register (if_id … mem_wb) and supplies the redirect PC.
- Runs a stall watchdog; optional statistics counters.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every exception except eret
- FLUSH_CYCLES, 1, cycles flush stays high per exception (legal 1..15)
- STALL_TIMEOUT, 1023, consecutive stall[0] cycles that raise stall_timeout (legal 1..65535)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- stallreq_from_if  in  1  fetch stall request
- stallreq_from_id  in  1  decode stall request
- stallreq_from_ex  in  1  execute stall request
- stallreq_from_mem  in  1  memory-stage stall request
- excepttype_i  in  32  exception type from mem stage; 0 = none
- cp0_epc_i  in  32  current CP0 EPC
- timeout_clr  in  1  clears sticky stall_timeout
- stall  out  6  bit i = 1 stops stage i (0 pc … 5 wb)
- flush  out  1  clears all pipeline registers
- new_pc  out  32  redirect target, valid while flush = 1
- busy  out  1  high in FLUSH state
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst = 1): state = IDLE; stall = 0, flush = 0, new_pc = 0, busy = 0, stall_timeout = 0; all counters = 0.
- State IDLE
  - stall is combinational from requests, highest priority wins:
    - mem → 6'b011111
    - ex → 6'b001111
    - id → 6'b000111
    - if → 6'b000011
    - none → 0
  - excepttype_i != 0 overrides all requests in the same cycle:
    - outputs: flush = 1, stall = 0.
    - new_pc (combinational this cycle, then registered): cp0_epc_i if excepttype_i == 32'h0000000e (eret), else EXC_VECTOR.
    - If FLUSH_CYCLES > 1, go to FLUSH with flush_cnt = FLUSH_CYCLES-1; otherwise stay in IDLE.
- State FLUSH
  - flush = 1, stall = 0, busy = 1.
  - new_pc holds the latched value; stall requests and excepttype_i are ignored.
  - flush_cnt decrements each cycle; when it reaches 1, go to IDLE on the next edge.
  - Total flush high time is exactly FLUSH_CYCLES cycles.
- Watchdog (16-bit counter)
  - Increments each cycle stall[0] = 1; resets to 0 on any cycle with stall[0] = 0.
  - When it equals STALL_TIMEOUT-1 while stall[0] = 1, stall_timeout sets on the next edge and the counter saturates.
  - timeout_clr = 1 clears the flag and the counter. If a set condition occurs in the same cycle, clear wins.
- Boundaries
  - Exception in the same cycle as stallreq_from_mem: flush wins and stall = 0.
  - Back-to-back exceptions in IDLE: each one flushes.
  - Reset during FLUSH returns immediately to IDLE with all outputs 0.

Optional Feature:
- Macro PIPE_CTRL_STATS_EN.
- When defined, adds three outputs, each cleared by reset and wrapping at 2^32:
  - stall_cycles (32) counts cycles with stall != 0
  - flush_count (32) counts exception entries
  - eret_count (32) counts eret entries
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release rst, no requests → stall = 0, flush = 0, new_pc = 0; assert rst asynchronously mid-cycle → outputs 0 before the next edge.
- stallreq_from_id = 1 and stallreq_from_ex = 1 together → stall = 6'b001111; add stallreq_from_mem → 6'b011111; drop all → 0 in the same cycle.
- excepttype_i = 32'h00000008 with stallreq_from_mem = 1, FLUSH_CYCLES = 3 → flush high exactly 3 cycles, stall = 0, new_pc = 32'h00000020, busy high for cycles 2–3.
- excepttype_i = 32'h0000000e, cp0_epc_i = 32'h00400104 → flush = 1, new_pc = 32'h00400104; cp0_epc_i changing during the FLUSH window does not change new_pc.
- STALL_TIMEOUT = 8, stallreq_from_if held 8 cycles → stall_timeout rises after the 8th cycle and stays high after the request drops; timeout_clr pulse → 0.
- With PIPE_CTRL_STATS_EN: 5 stall cycles, 2 exceptions (one eret) → stall_cycles = 5, flush_count = 2, eret_count = 1.
